// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    typedef logic [3:0] key_code_t;

    localparam logic [3:0] COL_0     = 4'b1110;
    localparam logic [3:0] COL_1     = 4'b1101;
    localparam logic [3:0] COL_2     = 4'b1011;
    localparam logic [3:0] COL_3     = 4'b0111;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drive;
        case (idx)
            2'd0:    drive = COL_0;
            2'd1:    drive = COL_1;
            2'd2:    drive = COL_2;
            2'd3:    drive = COL_3;
            default: drive = COL_0;
        endcase
        return drive;
    endfunction

    // Lowest-numbered row pulled low wins when several rows are active.
    function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// Scan-tick generator: one-clock pulse every SCAN_DIV clocks.
module keypad_tick #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    logic [15:0] r_cnt;
    logic        r_tick;

    // Free-running divider with a registered terminal-count pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= 16'd0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= 16'd0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates the column drive, debounces the first key found, delivers its code.
// Defining KEYPAD_REPEAT_EN enables auto-repeat of a held key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 50
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output key_code_t key_code,
    output logic      key_valid,
    input  logic      key_ack,
    output logic      keydown,
    output logic      overrun
);

`ifdef KEYPAD_REPEAT_EN
    localparam logic REPEAT_ON = 1'b1;
`else
    localparam logic REPEAT_ON = 1'b0;
`endif

    localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE);
    localparam logic [15:0] REP_DLY  = 16'(REPEAT_DELAY);
    localparam logic [15:0] REP_RATE = 16'(REPEAT_RATE);

    logic        w_tick;
    logic [3:0]  r_row_meta, r_row_sync;
    state_e      r_state, w_state_nx;
    logic [1:0]  r_col_idx, w_col_idx_nx;
    logic [3:0]  r_col;
    logic [3:0]  r_cand_row, w_cand_row_nx;
    key_code_t   r_cand_code, w_cand_code_nx;
    logic [3:0]  r_db_cnt, w_db_cnt_nx, w_db_inc;
    logic [15:0] r_rep_cnt, w_rep_cnt_nx, w_rep_inc;
    logic        r_rep_first, w_rep_first_nx, w_rep_hit;
    logic        r_keydown, w_keydown_nx;
    logic        w_deliver;
    key_code_t   r_key_code, w_key_code_nx;
    logic        r_key_valid, w_key_valid_nx;
    logic        r_overrun, w_overrun_nx;

    keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    assign w_db_inc  = r_db_cnt + 4'd1;
    assign w_rep_inc = r_rep_cnt + 16'd1;
    assign w_rep_hit = r_rep_first ? (w_rep_inc == REP_DLY) : (w_rep_inc == REP_RATE);

    // Next-state logic; row is only looked at on scan ticks.
    always_comb begin
        w_state_nx      = r_state;
        w_col_idx_nx    = r_col_idx;
        w_cand_row_nx   = r_cand_row;
        w_cand_code_nx  = r_cand_code;
        w_db_cnt_nx     = r_db_cnt;
        w_rep_cnt_nx    = r_rep_cnt;
        w_rep_first_nx  = r_rep_first;
        w_keydown_nx    = r_keydown;
        w_deliver       = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (!w_tick) begin
                    w_state_nx = ST_SCAN;
                end else if (r_row_sync == ROWS_IDLE) begin
                    w_col_idx_nx = r_col_idx + 2'd1;
                end else begin
                    w_cand_row_nx  = r_row_sync;
                    w_cand_code_nx = {low_row_idx(r_row_sync), r_col_idx};
                    w_db_cnt_nx    = 4'd0;
                    w_state_nx     = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_tick) begin
                    w_state_nx = ST_DEBOUNCE;
                end else if (r_row_sync != r_cand_row) begin
                    w_state_nx = ST_SCAN;
                end else if (w_db_inc == DB_LAST) begin
                    w_db_cnt_nx    = w_db_inc;
                    w_state_nx     = ST_PRESSED;
                    w_keydown_nx   = 1'b1;
                    w_deliver      = 1'b1;
                    w_rep_cnt_nx   = 16'd0;
                    w_rep_first_nx = 1'b1;
                end else begin
                    w_db_cnt_nx = w_db_inc;
                end
            end
            ST_PRESSED: begin
                if (!w_tick) begin
                    w_state_nx = ST_PRESSED;
                end else if (r_row_sync == ROWS_IDLE) begin
                    w_state_nx     = ST_RELEASE;
                    w_db_cnt_nx    = 4'd0;
                    w_rep_cnt_nx   = 16'd0;
                    w_rep_first_nx = 1'b1;
                end else if (REPEAT_ON && w_rep_hit) begin
                    w_deliver      = 1'b1;
                    w_rep_cnt_nx   = 16'd0;
                    w_rep_first_nx = 1'b0;
                end else begin
                    w_rep_cnt_nx = w_rep_inc;
                end
            end
            ST_RELEASE: begin
                if (!w_tick) begin
                    w_state_nx = ST_RELEASE;
                end else if (r_row_sync != ROWS_IDLE) begin
                    w_state_nx = ST_PRESSED;
                end else if (w_db_inc == DB_LAST) begin
                    w_db_cnt_nx  = w_db_inc;
                    w_state_nx   = ST_SCAN;
                    w_keydown_nx = 1'b0;
                    w_col_idx_nx = r_col_idx + 2'd1;
                end else begin
                    w_db_cnt_nx = w_db_inc;
                end
            end
            default: begin
                w_state_nx = ST_SCAN;
            end
        endcase
    end

    // Consumer handshake: acknowledge is applied before any coincident delivery.
    always_comb begin
        w_key_code_nx = r_key_code;
        if (key_ack && r_key_valid) begin
            w_key_valid_nx = 1'b0;
            w_overrun_nx   = 1'b0;
        end else begin
            w_key_valid_nx = r_key_valid;
            w_overrun_nx   = r_overrun;
        end
        if (w_deliver && w_key_valid_nx) begin
            w_overrun_nx = 1'b1;
        end else if (w_deliver) begin
            w_key_code_nx  = r_cand_code;
            w_key_valid_nx = 1'b1;
        end else begin
            w_key_code_nx = r_key_code;
        end
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_meta  <= ROWS_IDLE;
            r_row_sync  <= ROWS_IDLE;
            r_state     <= ST_SCAN;
            r_col_idx   <= 2'd0;
            r_col       <= COL_0;
            r_cand_row  <= ROWS_IDLE;
            r_cand_code <= 4'd0;
            r_db_cnt    <= 4'd0;
            r_rep_cnt   <= 16'd0;
            r_rep_first <= 1'b1;
            r_keydown   <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_row_meta  <= row;
            r_row_sync  <= r_row_meta;
            r_state     <= w_state_nx;
            r_col_idx   <= w_col_idx_nx;
            r_col       <= col_drive(w_col_idx_nx);
            r_cand_row  <= w_cand_row_nx;
            r_cand_code <= w_cand_code_nx;
            r_db_cnt    <= w_db_cnt_nx;
            r_rep_cnt   <= w_rep_cnt_nx;
            r_rep_first <= w_rep_first_nx;
            r_keydown   <= w_keydown_nx;
            r_key_code  <= w_key_code_nx;
            r_key_valid <= w_key_valid_nx;
            r_overrun   <= w_overrun_nx;
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign keydown   = r_keydown;
    assign overrun   = r_overrun;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per scan tick; legal range 2..65535.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable ticks required for press or release; legal range 1..15.
REQ-003 Parameter REPEAT_DELAY, default 200: ticks held before first repeat (KEYPAD_REPEAT_EN only).
REQ-004 Parameter REPEAT_RATE, default 50: ticks between repeats (KEYPAD_REPEAT_EN only).
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 row  in  4  keypad rows, active low (pulled up); asynchronous to clk.
REQ-008 col  out  4  column drive, one-hot active low.
REQ-009 key_code  out  4  code of last accepted key, row_index*4 + col_index.
REQ-010 key_valid  out  1  key_code holds an unacknowledged key.
REQ-011 key_ack  in  1  consumer acknowledge; one-cycle pulse or held level.
REQ-012 keydown  out  1  debounced key currently held.
REQ-013 overrun  out  1  key lost because key_valid was still set.

Function
REQ-014 row SHALL pass through a 2-flop synchronizer; all row references below mean the synchronized value.
REQ-015 Tick SHALL pulse for one clk every SCAN_DIV cycles; row is sampled only on tick.
REQ-016 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-017 SCAN: on each tick with row==4'b1111, col SHALL rotate 1110->1101->1011->0111->1110.
REQ-018 SCAN: on a tick with row!=4'b1111, FSM SHALL capture candidate (lowest-index low row, current column), hold col, clear counter, go to DEBOUNCE.
REQ-019 DEBOUNCE: each tick with same row pattern increments counter; any different pattern returns to SCAN without rotating col.
REQ-020 On counter reaching DEBOUNCE, FSM SHALL go to PRESSED, set keydown=1 and deliver the candidate per REQ-023 on the next clk.
REQ-021 PRESSED: a tick with row==4'b1111 SHALL go to RELEASE with counter cleared; col stays held.
REQ-022 RELEASE: DEBOUNCE consecutive all-high ticks return to SCAN with keydown=0 and col advanced one step. Any low row on a tick returns to PRESSED with no new delivery.
REQ-023 Delivery with key_valid=0 SHALL load key_code and set key_valid=1.
REQ-023a Delivery with key_valid=1 SHALL set overrun=1 and leave key_code unchanged.
REQ-024 key_ack high SHALL clear key_valid and overrun in the same cycle.
REQ-024a When delivery and key_ack coincide, the ack is applied first, then the new key loads (key_valid stays 1, overrun 0).
REQ-025 key_ack while key_valid=0 SHALL have no effect.
REQ-026 Multiple keys: only the captured key is tracked. Extra keys in other columns are invisible while col is held.

Reset
REQ-027 reset_n low SHALL immediately force state=SCAN, col=4'b1110, key_code=0, key_valid=0, keydown=0, overrun=0, and clear the divider, counters and synchronizer to all-ones rows.
REQ-028 Reset mid-press SHALL drop the key with no delivery. After release, scanning SHALL restart from column 0 on the first tick.

Configuration
REQ-029 Macro KEYPAD_REPEAT_EN defined: in PRESSED, after REPEAT_DELAY ticks held, the same code SHALL be re-delivered every REPEAT_RATE ticks per REQ-023/REQ-023a. Any release resets the repeat timers.
REQ-030 KEYPAD_REPEAT_EN undefined: exactly one delivery per press. Repeat counters and REPEAT_* parameters have no logic effect.

Structure
REQ-031 Package keypad_pkg SHALL hold the FSM state enum, column one-hot constants, and the 4-bit key code typedef.
REQ-032 The tick divider SHALL be sub-module keypad_tick (clk, reset_n, tick), parameterized by SCAN_DIV.

Verification (SCAN_DIV=4, DEBOUNCE=3, REPEAT_DELAY=6, REPEAT_RATE=2)
REQ-033 Press key row2/col1 stable for 10 ticks -> key_code=4'h9, key_valid=1 after the 3rd stable tick. keydown=1 until 3 all-high ticks after release.
REQ-034 Bounce: row toggles on alternate ticks for 8 ticks -> no delivery, keydown stays 0, col resumes rotation.
REQ-035 Two presses (code 3, then code C) with no ack -> key_code=3, overrun=1. key_ack pulse -> key_valid=0, overrun=0.
REQ-036 Delivery and key_ack in the same cycle -> key_valid stays 1, new code visible, overrun=0.
REQ-037 reset_n asserted while in PRESSED -> all outputs zero and col=1110 asynchronously. No delivery after reset_n is released.
REQ-038 With KEYPAD_REPEAT_EN, hold code 5 for 12 ticks with ack after each -> deliveries at stable ticks 3, 9 and 11.
